// File: rtl/sdram_port_arbiter.sv
// Shares the single sdram_controller host port between an instruction-fetch master (A) and a data master (B).
// One transaction outstanding at a time; round robin, or A-preferred with a B anti-starvation limit.
module sdram_port_arbiter #(
    parameter int ADDR_WIDTH = 30,
    parameter bit FIXED_PRIO = 1'b0,
    parameter int MAX_BURST  = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  a_cs,
    input  logic [ADDR_WIDTH-1:0] a_addr,
    input  logic                  a_wr_en,
    input  logic [3:0]            a_bytesel,
    input  logic [31:0]           a_wdata,
    output logic [31:0]           a_rdata,
    output logic                  a_compl,
    input  logic                  b_cs,
    input  logic [ADDR_WIDTH-1:0] b_addr,
    input  logic                  b_wr_en,
    input  logic [3:0]            b_bytesel,
    input  logic [31:0]           b_wdata,
    output logic [31:0]           b_rdata,
    output logic                  b_compl,
    output logic                  m_cs,
    output logic [ADDR_WIDTH-1:0] m_addr,
    output logic                  m_wr_en,
    output logic [3:0]            m_bytesel,
    output logic [31:0]           m_wdata,
    input  logic [31:0]           m_rdata,
    input  logic                  m_compl,
    input  logic                  m_config_done,
    output logic [1:0]            dbg_state
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        GRANT_A = 2'd1,
        GRANT_B = 2'd2
    } state_t;

    localparam logic [3:0] BURST_LIMIT = 4'(MAX_BURST);

    state_t     state, state_next;
    logic       last_b, last_b_next;
    logic [3:0] burst_cnt, burst_cnt_next;
    logic       pick_b;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            last_b    <= 1'b1;
            burst_cnt <= 4'd0;
        end else begin
            state     <= state_next;
            last_b    <= last_b_next;
            burst_cnt <= burst_cnt_next;
        end
    end

    // Contention resolution; only meaningful when at least one port requests.
    always_comb begin
        pick_b = 1'b0;
        if (b_cs && !a_cs) begin
            pick_b = 1'b1;
        end else if (a_cs && b_cs) begin
            pick_b = FIXED_PRIO ? (burst_cnt == BURST_LIMIT) : !last_b;
        end
    end

    always_comb begin
        state_next     = state;
        last_b_next    = last_b;
        burst_cnt_next = burst_cnt;
        case (state)
            IDLE: begin
                if (!a_cs) burst_cnt_next = 4'd0;
                if (m_config_done && (a_cs || b_cs)) begin
                    if (pick_b) begin
                        state_next     = GRANT_B;
                        burst_cnt_next = 4'd0;
                    end else begin
                        state_next = GRANT_A;
                        if (burst_cnt != 4'hf) burst_cnt_next = burst_cnt + 4'd1;
                    end
                end
            end
            GRANT_A: begin
                if (m_compl) begin
                    state_next  = IDLE;
                    last_b_next = 1'b0;
                end
            end
            GRANT_B: begin
                if (m_compl) begin
                    state_next  = IDLE;
                    last_b_next = 1'b1;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // The grant is held until m_compl whatever the master does with cs.
    always_comb begin
        m_cs      = 1'b0;
        m_addr    = '0;
        m_wr_en   = 1'b0;
        m_bytesel = 4'd0;
        m_wdata   = 32'd0;
        a_compl   = 1'b0;
        b_compl   = 1'b0;
        a_rdata   = 32'd0;
        b_rdata   = 32'd0;
        case (state)
            GRANT_A: begin
                m_cs      = 1'b1;
                m_addr    = a_addr;
                m_wr_en   = a_wr_en;
                m_wdata   = a_wdata;
                m_bytesel = m_compl ? 4'd0 : a_bytesel;
                a_compl   = m_compl;
                a_rdata   = m_rdata;
            end
            GRANT_B: begin
                m_cs      = 1'b1;
                m_addr    = b_addr;
                m_wr_en   = b_wr_en;
                m_wdata   = b_wdata;
                m_bytesel = m_compl ? 4'd0 : b_bytesel;
                b_compl   = m_compl;
                b_rdata   = m_rdata;
            end
            default: ;
        endcase
    end

    assign dbg_state = state;

endmodule
